// File: rtl/kv_txn_scheduler.sv
// Round-robin transaction sequencer for the cuckoo-hashed key/value ledger.
// Probes table 1, then table 2, then reads, updates and writes back the value BRAM.
module kv_txn_scheduler #(
    parameter int RAM_WIDTH     = 32,
    parameter int RAM_ADDR_BITS = 9,
    parameter int ID_BITS       = 1,
    localparam int NUM_REQ      = 2 ** ID_BITS
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*RAM_WIDTH-1:0]   req_key,
    input  logic [NUM_REQ*RAM_WIDTH-1:0]   req_amount,
    input  logic [NUM_REQ*2-1:0]           req_op,
    output logic [RAM_ADDR_BITS-1:0]       h1_addr,
    output logic [RAM_ADDR_BITS-1:0]       h2_addr,
    input  logic [RAM_WIDTH-1:0]           h1_key_rdata,
    input  logic [RAM_WIDTH-1:0]           h2_key_rdata,
    input  logic [RAM_ADDR_BITS-1:0]       h1_vaddr_rdata,
    input  logic [RAM_ADDR_BITS-1:0]       h2_vaddr_rdata,
    output logic [RAM_ADDR_BITS-1:0]       val_addr,
    input  logic [RAM_WIDTH-1:0]           val_rdata,
    output logic [RAM_WIDTH-1:0]           val_wdata,
    output logic                           val_we,
    output logic                           busy,
    output logic                           rsp_valid,
    output logic [ID_BITS-1:0]             rsp_id,
    output logic [1:0]                     rsp_status,
    output logic [RAM_WIDTH-1:0]           rsp_value,
    output logic [RAM_ADDR_BITS-1:0]       rsp_value_addr
);

    localparam logic [1:0] OP_READ   = 2'b00;
    localparam logic [1:0] OP_CREDIT = 2'b01;
    localparam logic [1:0] OP_DEBIT  = 2'b10;
    localparam logic [1:0] OP_BAD    = 2'b11;

    localparam logic [1:0] ST_OK        = 2'd0;
    localparam logic [1:0] ST_NOT_FOUND = 2'd1;
    localparam logic [1:0] ST_REJECT    = 2'd2;
    localparam logic [1:0] ST_BAD_OP    = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_H1_RD,
        S_H1_CHK,
        S_H2_RD,
        S_H2_CHK,
        S_VAL_RD,
        S_VAL_UPD,
        S_RESP
    } state_t;

    state_t                   state_q, state_d;
    logic [ID_BITS-1:0]       ptr_q, ptr_d;
    logic [RAM_WIDTH-1:0]     key_q, key_d;
    logic [RAM_WIDTH-1:0]     amount_q, amount_d;
    logic [1:0]               op_q, op_d;
    logic [ID_BITS-1:0]       id_q, id_d;
    logic [RAM_ADDR_BITS-1:0] vaddr_q, vaddr_d;
    logic [1:0]               status_q, status_d;
    logic [RAM_WIDTH-1:0]     value_q, value_d;

    logic                     grant_vld;
    logic [ID_BITS-1:0]       grant_id;
    logic [ID_BITS-1:0]       cand;
    logic [RAM_WIDTH:0]       credit_sum;

    function automatic logic [RAM_ADDR_BITS-1:0] hash1(input logic [RAM_WIDTH-1:0] k);
        return k[RAM_ADDR_BITS-1:0];
    endfunction

    function automatic logic [RAM_ADDR_BITS-1:0] hash2(input logic [RAM_WIDTH-1:0] k);
        return k[2*RAM_ADDR_BITS-1:RAM_ADDR_BITS] ^ k[RAM_ADDR_BITS-1:0];
    endfunction

    // First valid requester at or after the pointer, wrapping.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ptr_q + ID_BITS'(k);
            if (!grant_vld && req_valid[cand]) begin
                grant_vld = 1'b1;
                grant_id  = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (reset_n && state_q == S_IDLE && grant_vld) begin
            req_ready = NUM_REQ'(1) << grant_id;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        key_d      = key_q;
        amount_d   = amount_q;
        op_d       = op_q;
        id_d       = id_q;
        vaddr_d    = vaddr_q;
        status_d   = status_q;
        value_d    = value_q;
        h1_addr    = '0;
        h2_addr    = '0;
        val_addr   = '0;
        val_wdata  = '0;
        val_we     = 1'b0;
        credit_sum = {1'b0, val_rdata} + {1'b0, amount_q};

        case (state_q)
            S_IDLE: begin
                if (grant_vld) begin
                    key_d    = req_key[int'(grant_id) * RAM_WIDTH +: RAM_WIDTH];
                    amount_d = req_amount[int'(grant_id) * RAM_WIDTH +: RAM_WIDTH];
                    op_d     = req_op[int'(grant_id) * 2 +: 2];
                    id_d     = grant_id;
                    ptr_d    = grant_id + ID_BITS'(1);
                    vaddr_d  = '0;
                    value_d  = '0;
                    if (req_op[int'(grant_id) * 2 +: 2] == OP_BAD) begin
                        status_d = ST_BAD_OP;
                        state_d  = S_RESP;
                    end else begin
                        status_d = ST_NOT_FOUND;
                        state_d  = S_H1_RD;
                    end
                end
            end
            S_H1_RD: begin
                h1_addr = hash1(key_q);
                state_d = S_H1_CHK;
            end
            S_H1_CHK: begin
                // Key 0 marks an empty slot and can never hit.
                if (h1_key_rdata == key_q && key_q != '0) begin
                    vaddr_d = h1_vaddr_rdata;
                    state_d = S_VAL_RD;
                end else begin
                    state_d = S_H2_RD;
                end
            end
            S_H2_RD: begin
                h2_addr = hash2(key_q);
                state_d = S_H2_CHK;
            end
            S_H2_CHK: begin
                if (h2_key_rdata == key_q && key_q != '0) begin
                    vaddr_d = h2_vaddr_rdata;
                    state_d = S_VAL_RD;
                end else begin
                    state_d = S_RESP;
                end
            end
            S_VAL_RD: begin
                val_addr = vaddr_q;
                state_d  = S_VAL_UPD;
            end
            S_VAL_UPD: begin
                val_addr = vaddr_q;
                status_d = ST_OK;
                value_d  = val_rdata;
                case (op_q)
                    OP_CREDIT: begin
                        if (credit_sum[RAM_WIDTH]) begin
                            status_d = ST_REJECT;
                        end else begin
                            value_d   = credit_sum[RAM_WIDTH-1:0];
                            val_wdata = credit_sum[RAM_WIDTH-1:0];
                            val_we    = 1'b1;
                        end
                    end
                    OP_DEBIT: begin
                        if (amount_q > val_rdata) begin
                            status_d = ST_REJECT;
                        end else begin
                            value_d   = val_rdata - amount_q;
                            val_wdata = val_rdata - amount_q;
                            val_we    = 1'b1;
                        end
                    end
                    default: ;
                endcase
                state_d = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Transaction context; only observed through outputs gated by state.
    always_ff @(posedge clock) begin
        key_q    <= key_d;
        amount_q <= amount_d;
        op_q     <= op_d;
        id_q     <= id_d;
        vaddr_q  <= vaddr_d;
        status_q <= status_d;
        value_q  <= value_d;
    end

    always_comb begin
        busy           = (state_q != S_IDLE);
        rsp_valid      = (state_q == S_RESP);
        rsp_id         = '0;
        rsp_status     = '0;
        rsp_value      = '0;
        rsp_value_addr = '0;
        if (state_q == S_RESP) begin
            rsp_id         = id_q;
            rsp_status     = status_q;
            rsp_value      = value_q;
            rsp_value_addr = vaddr_q;
        end
    end

endmodule

// File: tb/tb_kv_txn_scheduler.sv
// Directed bench for kv_txn_scheduler with behavioural hash and value BRAM models.
module tb_kv_txn_scheduler;

    localparam int W  = 32;
    localparam int AB = 9;
    localparam int IB = 1;
    localparam int NR = 2;

    logic            clock = 1'b0;
    logic            reset_n;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [NR*W-1:0] req_key;
    logic [NR*W-1:0] req_amount;
    logic [NR*2-1:0] req_op;
    logic [AB-1:0]   h1_addr, h2_addr, val_addr;
    logic [W-1:0]    h1_key_rdata, h2_key_rdata, val_rdata, val_wdata;
    logic [AB-1:0]   h1_vaddr_rdata, h2_vaddr_rdata;
    logic            val_we, busy, rsp_valid;
    logic [IB-1:0]   rsp_id;
    logic [1:0]      rsp_status;
    logic [W-1:0]    rsp_value;
    logic [AB-1:0]   rsp_value_addr;

    logic [W-1:0]  h1_key_mem [512];
    logic [AB-1:0] h1_vaddr_mem [512];
    logic [W-1:0]  h2_key_mem [512];
    logic [AB-1:0] h2_vaddr_mem [512];
    logic [W-1:0]  val_mem [512];

    int checks = 0;
    int errors = 0;

    kv_txn_scheduler #(.RAM_WIDTH(W), .RAM_ADDR_BITS(AB), .ID_BITS(IB)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_key(req_key), .req_amount(req_amount), .req_op(req_op),
        .h1_addr(h1_addr), .h2_addr(h2_addr),
        .h1_key_rdata(h1_key_rdata), .h2_key_rdata(h2_key_rdata),
        .h1_vaddr_rdata(h1_vaddr_rdata), .h2_vaddr_rdata(h2_vaddr_rdata),
        .val_addr(val_addr), .val_rdata(val_rdata), .val_wdata(val_wdata), .val_we(val_we),
        .busy(busy), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_status(rsp_status),
        .rsp_value(rsp_value), .rsp_value_addr(rsp_value_addr)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        h1_key_rdata   <= h1_key_mem[h1_addr];
        h1_vaddr_rdata <= h1_vaddr_mem[h1_addr];
        h2_key_rdata   <= h2_key_mem[h2_addr];
        h2_vaddr_rdata <= h2_vaddr_mem[h2_addr];
        val_rdata      <= val_mem[val_addr];
        if (val_we) val_mem[val_addr] <= val_wdata;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int id, input logic [W-1:0] key, input logic [W-1:0] amt,
                           input logic [1:0] op);
        req_key[id*W +: W]    = key;
        req_amount[id*W +: W] = amt;
        req_op[id*2 +: 2]     = op;
    endtask

    // Called in T1; samples up to 20 cycles for the response.
    task automatic wait_rsp(output int lat, output int we_n, output logic [W-1:0] wd,
                            output logic [1:0] st, output logic [W-1:0] val,
                            output logic [AB-1:0] addr, output logic [IB-1:0] id);
        bit got = 0;
        lat = 0; we_n = 0; wd = '0; st = '0; val = '0; addr = '0; id = '0;
        for (int n = 1; n <= 20 && !got; n++) begin
            if (n > 1) tick();
            if (val_we) begin
                we_n++;
                wd = val_wdata;
            end
            if (rsp_valid) begin
                got  = 1;
                lat  = n;
                st   = rsp_status;
                val  = rsp_value;
                addr = rsp_value_addr;
                id   = rsp_id;
            end
        end
    endtask

    task automatic run_txn(input string tag, input int rid, input logic [W-1:0] key,
                           input logic [W-1:0] amt, input logic [1:0] op, input int exp_lat,
                           input logic [1:0] exp_st, input logic [W-1:0] exp_val,
                           input logic [AB-1:0] exp_addr, input int exp_we,
                           input logic [W-1:0] exp_wd);
        int lat, we_n;
        logic [W-1:0] wd, val;
        logic [1:0] st;
        logic [AB-1:0] addr;
        logic [IB-1:0] id;
        set_req(rid, key, amt, op);
        req_valid = NR'(1) << rid;
        #1;
        check({tag, "_ready"}, 64'(req_ready), 64'(NR'(1) << rid));
        tick();
        req_valid = '0;
        wait_rsp(lat, we_n, wd, st, val, addr, id);
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_status"}, 64'(st), 64'(exp_st));
        check({tag, "_value"}, 64'(val), 64'(exp_val));
        check({tag, "_addr"}, 64'(addr), 64'(exp_addr));
        check({tag, "_id"}, 64'(id), 64'(rid));
        check({tag, "_we_cnt"}, 64'(we_n), 64'(exp_we));
        if (exp_we > 0) check({tag, "_wdata"}, 64'(wd), 64'(exp_wd));
        tick();
        check({tag, "_idle"}, 64'(busy), 64'(0));
    endtask

    initial begin
        int ids[4];
        logic [W-1:0] vals[4];
        int nrsp, rc0, rc1, bad;
        for (int i = 0; i < 512; i++) begin
            h1_key_mem[i] = '0; h1_vaddr_mem[i] = '0;
            h2_key_mem[i] = '0; h2_vaddr_mem[i] = '0;
            val_mem[i] = '0;
        end
        h1_key_mem[249] = 32'd249;        h1_vaddr_mem[249] = 9'd5;   val_mem[5] = 32'd100;
        h1_key_mem[1]   = 32'h0000_0123;  h1_vaddr_mem[1]   = 9'd11;
        h2_key_mem[3]   = 32'h0000_0401;  h2_vaddr_mem[3]   = 9'd7;   val_mem[7] = 32'd50;
        h1_key_mem[9'hAA] = 32'h0000_00AA; h1_vaddr_mem[9'hAA] = 9'd9; val_mem[9] = 32'hFFFF_FFF0;

        reset_n = 1'b0; req_valid = '0; req_key = '0; req_amount = '0; req_op = '0;
        repeat (3) tick();
        req_valid = 2'b11;
        #1;
        check("rst_ready", 64'(req_ready), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_val_we", 64'(val_we), 64'(0));
        check("rst_addrs", 64'({h1_addr, h2_addr, val_addr}), 64'(0));
        req_valid = '0;
        tick();
        reset_n = 1'b1;
        tick();

        // Table-1 hit, credit.
        run_txn("credit_h1", 0, 32'd249, 32'd20, 2'b01, 5, 2'd0, 32'd120, 9'd5, 1, 32'd120);
        check("credit_h1_mem", 64'(val_mem[5]), 64'(120));
        // Table-2 hit, debit to zero then reject.
        run_txn("debit_h2", 1, 32'h401, 32'd50, 2'b10, 7, 2'd0, 32'd0, 9'd7, 1, 32'd0);
        run_txn("debit_rej", 1, 32'h401, 32'd1, 2'b10, 7, 2'd2, 32'd0, 9'd7, 0, 32'd0);
        // Misses and illegal op.
        run_txn("miss", 0, 32'h55, 32'd1, 2'b00, 5, 2'd1, 32'd0, 9'd0, 0, 32'd0);
        run_txn("key0", 0, 32'h0, 32'd1, 2'b01, 5, 2'd1, 32'd0, 9'd0, 0, 32'd0);
        run_txn("bad_op", 1, 32'd249, 32'd1, 2'b11, 1, 2'd3, 32'd0, 9'd0, 0, 32'd0);
        // Credit overflow and read.
        run_txn("credit_ovf", 0, 32'hAA, 32'h20, 2'b01, 5, 2'd2, 32'hFFFF_FFF0, 9'd9, 0, 32'd0);
        run_txn("read", 1, 32'hAA, 32'd7, 2'b00, 5, 2'd0, 32'hFFFF_FFF0, 9'd9, 0, 32'd0);

        // Both requesters continuously valid.
        set_req(0, 32'd249, 32'd0, 2'b00);
        set_req(1, 32'hAA, 32'd0, 2'b00);
        req_valid = 2'b11;
        #1;
        nrsp = 0; rc0 = 0; rc1 = 0;
        for (int c = 0; c < 60 && nrsp < 4; c++) begin
            if (req_ready[0]) rc0++;
            if (req_ready[1]) rc1++;
            if (rsp_valid) begin
                ids[nrsp]  = int'(rsp_id);
                vals[nrsp] = rsp_value;
                nrsp++;
            end
            if (nrsp == 4) req_valid = '0;
            else tick();
        end
        check("rr_count", 64'(nrsp), 64'(4));
        check("rr_id0", 64'(ids[0]), 64'(0));
        check("rr_id1", 64'(ids[1]), 64'(1));
        check("rr_id2", 64'(ids[2]), 64'(0));
        check("rr_id3", 64'(ids[3]), 64'(1));
        check("rr_val0", 64'(vals[0]), 64'(120));
        check("rr_val1", 64'(vals[1]), 64'(32'hFFFF_FFF0));
        check("rr_ready0", 64'(rc0), 64'(2));
        check("rr_ready1", 64'(rc1), 64'(2));
        tick();

        // Reset while the credit is in VAL_RD.
        set_req(1, 32'd249, 32'd5, 2'b01);
        req_valid = 2'b10;
        #1;
        check("abort_ready", 64'(req_ready), 64'(2'b10));
        tick();
        tick();
        tick();
        check("abort_val_addr", 64'(val_addr), 64'(5));
        reset_n = 1'b0;
        set_req(0, 32'hAA, 32'd0, 2'b00);
        req_valid = 2'b11;
        bad = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (val_we || rsp_valid || busy || req_ready != 2'b00 || val_addr != '0) bad++;
        end
        check("abort_outputs_zero", 64'(bad), 64'(0));
        check("abort_no_write", 64'(val_mem[5]), 64'(120));
        reset_n = 1'b1;
        #1;
        check("post_rst_ready", 64'(req_ready), 64'(2'b01));
        begin
            int lat, we_n;
            logic [W-1:0] wd, val;
            logic [1:0] st;
            logic [AB-1:0] addr;
            logic [IB-1:0] id;
            tick();
            req_valid = '0;
            wait_rsp(lat, we_n, wd, st, val, addr, id);
            check("post_rst_lat", 64'(lat), 64'(5));
            check("post_rst_id", 64'(id), 64'(0));
            check("post_rst_status", 64'(st), 64'(0));
            check("post_rst_value", 64'(val), 64'(32'hFFFF_FFF0));
            check("post_rst_we", 64'(we_n), 64'(0));
        end
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/kv_txn_scheduler.md
Name: kv_txn_scheduler

Overview:
- Sequencer and arbiter for the key/value ledger datapath: two cuckoo hash tables (key + value-address per slot) plus a value BRAM.
- Accepts transaction requests from 2^ID_BITS requesters and grants one round-robin at a time.
- For the granted request it probes hash table 1, then hash table 2, reads the value, applies the read/credit/debit operation, writes back and returns one response.
- Sits between the transaction front-ends and the BRAM bank; it owns every BRAM address and write-enable.

Parameters:
- RAM_WIDTH, 32, key/value/amount width.
- RAM_ADDR_BITS, 9, address width of the hash and value BRAMs.
- ID_BITS, 1, requester index width; NUM_REQ = 2**ID_BITS.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  synchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester grant; handshake when valid&ready.
- req_key  in  NUM_REQ*RAM_WIDTH  packed keys; requester i at [i*RAM_WIDTH +: RAM_WIDTH].
- req_amount  in  NUM_REQ*RAM_WIDTH  packed transaction amounts.
- req_op  in  NUM_REQ*2  packed op: 00 read, 01 credit, 10 debit, 11 illegal.
- h1_addr, h2_addr  out  RAM_ADDR_BITS  hash table probe addresses.
- h1_key_rdata, h2_key_rdata  in  RAM_WIDTH  stored key; 1-cycle read latency.
- h1_vaddr_rdata, h2_vaddr_rdata  in  RAM_ADDR_BITS  stored value address.
- val_addr  out  RAM_ADDR_BITS  value BRAM address.
- val_rdata  in  RAM_WIDTH  value read data; 1-cycle latency.
- val_wdata  out  RAM_WIDTH  write data.
- val_we  out  1  value write enable.
- busy  out  1  high whenever the state is not IDLE.
- rsp_valid  out  1  one-cycle response pulse; no backpressure.
- rsp_id  out  ID_BITS  requester index.
- rsp_status  out  2  0 OK, 1 NOT_FOUND, 2 REJECT, 3 BAD_OP.
- rsp_value  out  RAM_WIDTH  resulting value (old value if not written); 0 if NOT_FOUND or BAD_OP.
- rsp_value_addr  out  RAM_ADDR_BITS  value address used; 0 if NOT_FOUND or BAD_OP.

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - State returns to IDLE; round-robin pointer = 0.
  - All outputs are 0: req_ready, val_we, rsp_*, busy, and all addresses.
  - Applies mid-transaction too: no write is issued and no response is produced for the aborted request.
- Arbitration (IDLE only):
  - Grant the lowest index >= pointer with req_valid=1, wrapping modulo NUM_REQ.
  - req_ready is combinational, asserted for the granted index only, and only in IDLE.
  - On handshake: capture key, amount, op and id; set pointer = id+1 mod NUM_REQ.
  - Requesters hold their request until ready; a valid that drops before grant is ignored.
- Hash functions:
  - h1 = key[RAM_ADDR_BITS-1:0].
  - h2 = key[2*RAM_ADDR_BITS-1:RAM_ADDR_BITS] ^ key[RAM_ADDR_BITS-1:0].
- FSM (handshake cycle = T0):
  - IDLE -> H1_RD (T1, drive h1_addr) -> H1_CHK (T2).
  - H1_CHK: if h1_key_rdata==key and key!=0, go to VAL_RD with vaddr=h1_vaddr_rdata; else go to H2_RD.
  - H2_RD (T3, drive h2_addr) -> H2_CHK (T4): on hit, go to VAL_RD with vaddr=h2_vaddr_rdata; else go to RESP with NOT_FOUND.
  - VAL_RD: drive val_addr=vaddr.
  - VAL_UPD: compute the result and assert val_we for 1 cycle when the op succeeds.
  - RESP: pulse rsp_valid, then return to IDLE.
  - Op 11 skips lookup: IDLE -> RESP, BAD_OP, rsp_valid at T1.
- Latency from handshake to rsp_valid:
  - Table-1 hit: T5.
  - Table-2 hit: T7.
  - Miss in both tables: T5.
  - BAD_OP: T1.
  - Next grant is possible in the cycle after RESP.
- Key 0 marks an empty slot; a request with key 0 always returns NOT_FOUND.
- Arithmetic:
  - Read: no write; status OK; rsp_value = old value.
  - Credit: new = old + amount, computed RAM_WIDTH+1 wide. If there is a carry-out, status is REJECT and no write occurs; otherwise write new and status is OK.
  - Debit: if amount > old, status is REJECT and no write occurs; otherwise write old - amount. A debit to exactly 0 is OK.
- val_addr, val_wdata and val_we are stable in the same cycle; val_we is never asserted outside VAL_UPD.
- Exactly one response per accepted request; responses are returned in acceptance order.

Test Plan:
- Preload h1[249]=key 249 / vaddr 5 and val[5]=100. Credit 20 on key 249 from requester 0 -> rsp at T5: OK, value 120, addr 5; val_we one cycle with wdata 120.
- Key 0x0000_0401 (h1=1, h2=3), with h1[1] holding a different key and h2[3]={0x401, vaddr 7}, val[7]=50. Debit 50 -> rsp at T7: OK, value 0. Repeat debit 1 -> REJECT, value 0, no val_we.
- Key absent in both tables -> NOT_FOUND at T5 with value/addr 0. Key 0 -> NOT_FOUND. Op 11 -> BAD_OP at T1. No val_we in any of these cases.
- val=0xFFFF_FFF0, credit 0x20 -> REJECT, value 0xFFFF_FFF0, no write. Read op -> OK, old value returned, no write.
- Both requesters valid continuously -> grants alternate 0,1,0,1; rsp_id matches; each requester is ready exactly once per response.
- reset_n low during VAL_RD of a credit -> no val_we, no rsp_valid, outputs 0. After release, a pending request is granted and completes normally with pointer 0 priority.
